// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// dcache_pkg : FSM encoding and address-field width helpers for dcache_2way
// Rev 1.0
// ============================================================================
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// ============================================================================
// dcache_way : valid/tag/data storage for one way, combinational lookup
// Rev 1.0
// ============================================================================
module dcache_way #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 23,
  parameter int WSEL_W     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_BITS-1:0]        idx_i,
  input  logic [TAG_BITS-1:0]          tag_i,
  output logic                         hit_o,
  output logic                         valid_o,
  output logic [LINE_WORDS*DATA_W-1:0] line_o,
  input  logic                         fill_en_i,
  input  logic [LINE_WORDS*DATA_W-1:0] fill_line_i,
  input  logic                         wr_en_i,
  input  logic [WSEL_W-1:0]            wr_word_i,
  input  logic [DATA_W-1:0]            wr_data_i
);

  logic [SETS-1:0]              valid_q;
  logic [TAG_BITS-1:0]          tag_q  [SETS];
  logic [LINE_WORDS*DATA_W-1:0] data_q [SETS];

  assign valid_o = valid_q[idx_i];
  assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Tag/data carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[idx_i][int'(wr_word_i)*DATA_W +: DATA_W] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_2way.sv
`default_nettype none
// ============================================================================
// dcache_2way : 2-way set-associative write-through, no-write-allocate D-cache
// Rev 1.0
// ============================================================================
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         ready_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [ADDR_W-1:0]            sram_addr_o,
  output logic [DATA_W-1:0]            sram_wdata_o,
  input  logic [LINE_WORDS*DATA_W-1:0] sram_rdata_i,
  input  logic                         sram_ack_i
);

  localparam int WORD_BITS  = word_bits(LINE_WORDS);
  localparam int INDEX_BITS = index_bits(SETS);
  localparam int TAG_BITS   = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int WSEL_W     = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int IDX_LSB    = 2 + WORD_BITS;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * 4 - 1));

  state_e                      state_q, state_d;
  logic [SETS-1:0]             lru_q;
  logic                        lru_we, lru_d;
  logic                        sram_req_q, sram_req_d;
  logic                        sram_we_q, sram_we_d;
  logic [ADDR_W-1:0]           sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]           sram_wdata_q, sram_wdata_d;

  logic [ADDR_W-1:0]           lookup_addr;
  logic [INDEX_BITS-1:0]       lookup_idx;
  logic [TAG_BITS-1:0]         lookup_tag;
  logic [WSEL_W-1:0]           req_word;
  logic [1:0]                  hit, valid, fill_en, wr_way;
  logic                        hit_any, victim;
  logic [LINE_WORDS*DATA_W-1:0] line [2];
  logic [LINE_WORDS*DATA_W-1:0] line_sel;
  logic [DATA_W-1:0]           hit_word;

  // While filling, the ways are addressed by the outstanding line address.
  assign lookup_addr = (state_q == S_FILL) ? sram_addr_q : addr_i;
  assign lookup_idx  = lookup_addr[IDX_LSB +: INDEX_BITS];
  assign lookup_tag  = lookup_addr[ADDR_W-1 -: TAG_BITS];

  if (WORD_BITS > 0) begin : g_wsel
    assign req_word = addr_i[2 +: WSEL_W];
  end else begin : g_no_wsel
    assign req_word = '0;
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .SETS       (SETS),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS),
      .WSEL_W     (WSEL_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .idx_i       (lookup_idx),
      .tag_i       (lookup_tag),
      .hit_o       (hit[w]),
      .valid_o     (valid[w]),
      .line_o      (line[w]),
      .fill_en_i   (fill_en[w]),
      .fill_line_i (sram_rdata_i),
      .wr_en_i     (wr_way[w]),
      .wr_word_i   (req_word),
      .wr_data_i   (wdata_i)
    );
  end

  assign hit_any  = |hit;
  assign line_sel = hit[0] ? line[0] : line[1];
  assign hit_word = line_sel[int'(req_word)*DATA_W +: DATA_W];
  assign victim   = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru_q[lookup_idx]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wr_en_i) state_d = S_WRITE;
               else if (rd_en_i && !hit_any) state_d = S_FILL;
      S_FILL:  if (sram_ack_i) state_d = S_IDLE;
      S_WRITE: if (sram_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    rdata_o      = '0;
    fill_en      = 2'b00;
    wr_way       = 2'b00;
    lru_we       = 1'b0;
    lru_d        = 1'b0;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en_i) begin
          sram_req_d   = 1'b1;
          sram_we_d    = 1'b1;
          sram_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
          sram_wdata_d = wdata_i;
          wr_way       = hit;
          lru_we       = hit_any;
          lru_d        = hit[0];
        end else if (rd_en_i) begin
          if (hit_any) begin
            ready_o = 1'b1;
            rdata_o = hit_word;
            lru_we  = 1'b1;
            lru_d   = hit[0];
          end else begin
            sram_req_d  = 1'b1;
            sram_we_d   = 1'b0;
            sram_addr_d = addr_i & LINE_MASK;
          end
        end else begin
          ready_o = 1'b1;
        end
      end
      S_FILL: begin
        if (sram_ack_i) begin
          fill_en    = victim ? 2'b10 : 2'b01;
          lru_we     = 1'b1;
          lru_d      = ~victim;
          sram_req_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (sram_ack_i) sram_req_d = 1'b0;
      end
      S_DONE: begin
        ready_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q        <= '0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      if (lru_we) lru_q[lookup_idx] <= lru_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign sram_req_o   = sram_req_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way.sv
`default_nettype none
// ============================================================================
// tb_dcache_2way : scoreboard bench for dcache_2way with a delayed-ack SRAM
// Rev 1.0
// ============================================================================
module tb_dcache_2way;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_req, sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ack;

  dcache_2way #(.ADDR_W(32), .DATA_W(32), .SETS(64), .LINE_WORDS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (rd_en),
    .wr_en_i      (wr_en),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .ready_o      (ready),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .sram_ack_i   (sram_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] exp_q   [$];

  int          ack_k = 3;
  int          wait_cnt = 0;
  int          txn_cnt = 0;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
  endfunction

  // SRAM controller model: ack ack_k cycles after the request rises.
  initial begin
    sram_ack   = 1'b0;
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      sram_ack = 1'b0;
      if (rst || !sram_req) begin
        wait_cnt = 0;
      end else if (wait_cnt == ack_k) begin
        sram_ack   = 1'b1;
        txn_cnt++;
        last_we    = sram_we;
        last_addr  = sram_addr;
        last_wdata = sram_wdata;
        if (sram_we) mem[sram_addr] = sram_wdata;
        else sram_rdata = {sram_word(sram_addr + 32'd4), sram_word(sram_addr)};
        wait_cnt = ack_k + 1;
      end else if (wait_cnt < ack_k) begin
        wait_cnt++;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit miss);
    int low = 0;
    int tx0 = txn_cnt;
    exp_q.push_back(exp_word({a[31:2], 2'b00}));
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; addr = a;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready) break;
      low++;
    end
    if (!ready) chk($sformatf("rd_timeout_%h", a), 0, 1);
    chk($sformatf("rd_stall_%h", a), low, miss ? ack_k + 2 : 0);
    chk($sformatf("rdata_%h", a), rdata, exp_q.pop_front());
    chk($sformatf("rd_req_low_%h", a), sram_req, 0);
    chk($sformatf("rd_txns_%h", a), txn_cnt - tx0, miss ? 1 : 0);
    if (miss) begin
      chk($sformatf("fill_we_%h", a), last_we, 0);
      chk($sformatf("fill_addr_%h", a), last_addr, a & ~32'h7);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both, input int reps);
    int low;
    int tx0 = txn_cnt;
    exp_mem[{a[31:2], 2'b00}] = d;
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = both; addr = a; wdata = d;
    for (int r = 0; r < reps; r++) begin
      low = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (ready) break;
        low++;
      end
      if (!ready) chk($sformatf("wr_timeout_%h", a), 0, 1);
      chk($sformatf("wr_stall_%h_%0d", a, r), low, ack_k + 2);
    end
    chk($sformatf("wr_txns_%h", a), txn_cnt - tx0, reps);
    chk($sformatf("wr_we_%h", a), last_we, 1);
    chk($sformatf("wr_addr_%h", a), last_addr, {a[31:2], 2'b00});
    chk($sformatf("wr_wdata_%h", a), last_wdata, d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    mem[32'h100] = 32'h1111_1111;  mem[32'h104] = 32'h2222_2222;
    exp_mem[32'h100] = 32'h1111_1111; exp_mem[32'h104] = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_req", sram_req, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);

    ack_k = 3;
    do_read(32'h100, 1);
    do_read(32'h104, 0);

    ack_k = 0;
    do_read(32'h300, 1);
    do_read(32'h100, 0);
    do_read(32'h500, 1);
    do_read(32'h100, 0);
    do_read(32'h300, 1);

    ack_k = 1;
    do_write(32'h104, 32'hDEAD_BEEF, 0, 2);
    do_write(32'h900, 32'h0000_0005, 0, 1);
    do_read(32'h104, 0);
    do_read(32'h900, 1);

    do_write(32'h104, 32'h0000_0007, 1, 1);
    do_read(32'h104, 0);

    ack_k = 20;
    @(posedge clk); #1;
    rd_en = 1'b1; addr = 32'h700;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midfill_req", sram_req, 0);
    chk("midfill_ready", ready, 1);
    ack_k = 2;
    do_read(32'h104, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
